stack_sequencer: RTL and testbench
==================================

STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 Parameter DEPTH, default 8: stack capacity in entries, matching the stack it drives.
REQ-002 Parameter WIDTH, default 8: data word width.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 instr_valid  in  1  instruction offered.
REQ-006 instr_ready  out  1  sequencer can accept; high only in IDLE.
REQ-007 opcode  in  3  000 NOP, 001 PUSH, 010 POP, 011 DUP, 100 ADD, 101 SUB, 110 AND, 111 XOR.
REQ-008 imm  in  WIDTH  PUSH operand.
REQ-009 push_sig  out  1  push strobe to stack, one cycle per push.
REQ-010 pop_sig  out  1  pop strobe to stack, one cycle per pop.
REQ-011 tos_sig  out  1  top-of-stack read request, one cycle.
REQ-012 push_data  out  WIDTH  value pushed; meaningful only while push_sig high.
REQ-013 tos_data  in  WIDTH  stack top value; valid the cycle after tos_sig.
REQ-014 done  out  1  one-cycle pulse on completion of each accepted instruction.
REQ-015 err  out  1  one-cycle pulse coincident with done when the instruction was rejected.
REQ-016 result  out  WIDTH  last value pushed by this block.
REQ-017 depth  out  $clog2(DEPTH)+1  occupancy count tracked by this block.

Function
REQ-018 Accept on posedge with instr_valid and instr_ready; latch opcode and imm; leave IDLE in the same edge.
REQ-019 States: IDLE, PUSH, POP, TOS_A, LAT_A, TOS_B, LAT_B, PUSH_R, FIN.
REQ-020 NOP: IDLE->FIN; done in FIN; FIN->IDLE.
REQ-021 PUSH: IDLE->PUSH (push_sig=1, push_data=imm, done=1)->IDLE; push_sig in cycle k+1 after acceptance edge k.
REQ-022 POP: IDLE->POP (pop_sig=1, done=1)->IDLE.
REQ-023 DUP: TOS_A (tos_sig)->LAT_A (capture A=tos_data, no pop)->PUSH_R (push A, done).
REQ-024 Binary: TOS_A->LAT_A (capture A, pop_sig)->TOS_B->LAT_B (capture B, pop_sig)->PUSH_R (push B op A, done); 5 cycles after acceptance.
REQ-025 SUB result = B - A (B is the deeper operand); all arithmetic WIDTH-bit modulo, carry discarded.
REQ-026 At most one of push_sig, pop_sig, tos_sig is high in any cycle.
REQ-027 depth increments on each push_sig cycle and decrements on each pop_sig cycle; never wraps.
REQ-028 result updates to push_data in every push_sig cycle; otherwise holds.
REQ-029 instr_valid while not ready is ignored; opcode/imm changes after acceptance have no effect.

Reset
REQ-030 rst_n low forces, immediately and independent of clk: state IDLE, push_sig/pop_sig/tos_sig/done/err 0, push_data 0, result 0, depth 0.
REQ-031 Reset mid-instruction abandons it with no further strobes; instr_ready asserts in the first cycle after release.

Configuration
REQ-032 With STACK_SEQ_GUARD_EN defined: on acceptance, PUSH/DUP with depth==DEPTH, POP/DUP with depth==0, or binary op with depth<2 goes IDLE->FIN with err=1 and done=1, no stack strobes, depth unchanged.
REQ-033 Without STACK_SEQ_GUARD_EN: no checks, err tied 0, all instructions execute; depth saturates at 0 and DEPTH.

Structure
REQ-034 Package stack_seq_pkg holds opcode encodings, state typedef, default DEPTH and WIDTH.
REQ-035 Sub-module stack_seq_alu computes B op A combinationally from latched operands and opcode.

Verification
REQ-036 Reset, PUSH imm=8'h05 -> push_sig one cycle with push_data 05, done same cycle, depth 1, result 05.
REQ-037 PUSH 8'hF0, PUSH 8'h20, ADD -> pops twice, pushes 8'h10 (wrap), depth 1, done 5 cycles after ADD accepted.
REQ-038 PUSH 03, PUSH 07, SUB -> pushes 8'h FC (03-07), DUP -> pushes FC, depth 2.
REQ-039 Guard on: POP at depth 0 -> done=err=1, no strobes, depth 0; 9th PUSH at depth 8 -> err, depth stays 8.
REQ-040 rst_n low during LAT_B of XOR -> strobes drop at once, depth 0, no done; instr_ready high after release.
REQ-041 Every cycle: at most one strobe high; instr_valid held high while busy never causes a second acceptance.

Source files
------------

// File: rtl/stack_seq_pkg.sv
// Shared encodings for the stack sequencer: opcodes, FSM state codes, default sizing.
// The STACK_SEQ_GUARD_EN build option is handled in stack_sequencer.sv.
package stack_seq_pkg;

  localparam int DEF_DEPTH = 8;
  localparam int DEF_WIDTH = 8;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_DUP  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE   = 4'd0;
  localparam state_t S_PUSH   = 4'd1;
  localparam state_t S_POP    = 4'd2;
  localparam state_t S_TOS_A  = 4'd3;
  localparam state_t S_LAT_A  = 4'd4;
  localparam state_t S_TOS_B  = 4'd5;
  localparam state_t S_LAT_B  = 4'd6;
  localparam state_t S_PUSH_R = 4'd7;
  localparam state_t S_FIN    = 4'd8;

  // Binary ops all have opcode MSB set.
  function automatic logic is_binary(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/stack_seq_alu.sv
// Combinational result for the PUSH_R step: B op A, with B the deeper operand.
// DUP passes A through unchanged.
module stack_seq_alu
  import stack_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = a_i;
    case (op_i)
      OP_ADD:  y_o = b_i + a_i;
      OP_SUB:  y_o = b_i - a_i;
      OP_AND:  y_o = b_i & a_i;
      OP_XOR:  y_o = b_i ^ a_i;
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/stack_sequencer.sv
// Instruction sequencer driving push/pop/top-of-stack strobes of an external stack.
// Define STACK_SEQ_GUARD_EN to reject instructions that would over/underflow the stack.
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [2:0]             opcode,
  input  logic [WIDTH-1:0]       imm,
  output logic                   push_sig,
  output logic                   pop_sig,
  output logic                   tos_sig,
  output logic [WIDTH-1:0]       push_data,
  input  logic [WIDTH-1:0]       tos_data,
  output logic                   done,
  output logic                   err,
  output logic [WIDTH-1:0]       result,
  output logic [$clog2(DEPTH):0] depth
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] imm_q, a_q, b_q, result_q, alu_y;
  logic [DW-1:0]    depth_q, depth_d;
  logic             accept, reject;

  assign instr_ready = (state_q == S_IDLE);
  assign accept      = instr_valid && instr_ready;

`ifdef STACK_SEQ_GUARD_EN
  logic err_q;

  always_comb begin
    reject = 1'b0;
    case (opcode)
      OP_PUSH: reject = (depth_q == FULL);
      OP_POP:  reject = (depth_q == '0);
      OP_DUP:  reject = (depth_q == FULL) || (depth_q == '0);
      default: reject = is_binary(opcode) && (depth_q < DW'(2));
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= reject;
  end

  assign err = (state_q == S_FIN) && err_q;
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (reject) state_d = S_FIN;
          else begin
            case (opcode)
              OP_NOP:  state_d = S_FIN;
              OP_PUSH: state_d = S_PUSH;
              OP_POP:  state_d = S_POP;
              default: state_d = S_TOS_A;
            endcase
          end
        end
      end
      S_TOS_A: state_d = S_LAT_A;
      S_LAT_A: state_d = (op_q == OP_DUP) ? S_PUSH_R : S_TOS_B;
      S_TOS_B: state_d = S_LAT_B;
      S_LAT_B: state_d = S_PUSH_R;
      default: state_d = S_IDLE;
    endcase
  end

  stack_seq_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .y_o  (alu_y)
  );

  // DUP reads the top without consuming it; binary ops pop each operand.
  assign push_sig  = (state_q == S_PUSH) || (state_q == S_PUSH_R);
  assign pop_sig   = (state_q == S_POP) || (state_q == S_LAT_B) ||
                     ((state_q == S_LAT_A) && (op_q != OP_DUP));
  assign tos_sig   = (state_q == S_TOS_A) || (state_q == S_TOS_B);
  assign done      = push_sig || (state_q == S_POP) || (state_q == S_FIN);
  assign push_data = (state_q == S_PUSH)   ? imm_q :
                     (state_q == S_PUSH_R) ? alu_y : '0;

  always_comb begin
    depth_d = depth_q;
    if (push_sig && (depth_q != FULL))    depth_d = depth_q + 1'b1;
    else if (pop_sig && (depth_q != '0)) depth_d = depth_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOP;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      depth_q  <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      if (accept) begin
        op_q  <= opcode;
        imm_q <= imm;
      end
      if (state_q == S_LAT_A) a_q <= tos_data;
      if (state_q == S_LAT_B) b_q <= tos_data;
      if (push_sig)           result_q <= push_data;
    end
  end

  assign result = result_q;
  assign depth  = depth_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed self-checking bench for stack_sequencer with a simple behavioural stack attached.
module tb_stack_sequencer;

  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, DUP = 3'b011;
  localparam logic [2:0] ADD = 3'b100, SUB = 3'b101, AND = 3'b110, XOR = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n, instr_valid, instr_ready;
  logic [2:0] opcode;
  logic [7:0] imm, push_data, tos_data, result;
  logic       push_sig, pop_sig, tos_sig, done, err;
  logic [3:0] depth;

  int checks = 0, errors = 0;
  int push_cnt = 0, pop_cnt = 0, tos_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic [7:0] last_push = 8'h00;
  int p0, q0, t0, d0, e0, lat;

  always #5 clk = ~clk;

  stack_sequencer #(.DEPTH(8), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .imm(imm), .push_sig(push_sig), .pop_sig(pop_sig), .tos_sig(tos_sig),
    .push_data(push_data), .tos_data(tos_data), .done(done), .err(err),
    .result(result), .depth(depth)
  );

  // Behavioural stack: top-of-stack read returns the value one cycle after tos_sig.
  logic [7:0] stk [0:15];
  int sp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp       <= 0;
      tos_data <= 8'h00;
    end else begin
      if (tos_sig) tos_data <= (sp > 0) ? stk[sp-1] : 8'h00;
      if (push_sig && sp < 16) begin
        stk[sp] <= push_data;
        sp      <= sp + 1;
      end else if (pop_sig && sp > 0) sp <= sp - 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (push_sig) begin push_cnt++; last_push = push_data; end
      if (pop_sig)  pop_cnt++;
      if (tos_sig)  tos_cnt++;
      if (done)     done_cnt++;
      if (err)      err_cnt++;
      checks++;
      if (int'(push_sig) + int'(pop_sig) + int'(tos_sig) > 1) begin
        errors++;
        $display("FAIL strobe_onehot: push=%0b pop=%0b tos=%0b, at most one required", push_sig, pop_sig, tos_sig);
      end
    end
  end

  task automatic snap();
    p0 = push_cnt; q0 = pop_cnt; t0 = tos_cnt; d0 = done_cnt; e0 = err_cnt;
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] v);
    instr_valid = 1'b1; opcode = op; imm = v;
    for (int t = 0; t < 20 && !instr_ready; t++) @(negedge clk);
    @(posedge clk);
    #1;
    instr_valid = 1'b0; opcode = XOR; imm = 8'hAA;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 12);
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done after %0d cycles", n);
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [7:0] v, output int n);
    issue(op, v);
    wait_done(n);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; opcode = NOP; imm = 8'h00;
    #1;
    checks++;
    if ({push_sig, pop_sig, tos_sig, done, err} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 00000", {push_sig, pop_sig, tos_sig, done, err});
    end
    checks++;
    if ({push_data, result, depth} !== 20'h0) begin
      errors++; $display("FAIL reset_data: push_data=%h result=%h depth=%0d want 0", push_data, result, depth);
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", instr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_push();
    do_reset(); snap();
    run(PUSH, 8'h05, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL push_latency: got %0d want 1", lat); end
    checks++; if (push_cnt - p0 !== 1 || last_push !== 8'h05) begin
      errors++; $display("FAIL push_strobe: pushes=%0d data=%h want 1/05", push_cnt - p0, last_push); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL push_done: got %0d want 1", done_cnt - d0); end
    checks++; if (depth !== 4'd1 || result !== 8'h05) begin
      errors++; $display("FAIL push_state: depth=%0d result=%h want 1/05", depth, result); end
  endtask

  task automatic test_add();
    do_reset();
    run(PUSH, 8'hF0, lat); run(PUSH, 8'h20, lat);
    snap();
    run(ADD, 8'h00, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL add_latency: got %0d want 5", lat); end
    checks++; if (pop_cnt - q0 !== 2 || tos_cnt - t0 !== 2 || push_cnt - p0 !== 1) begin
      errors++; $display("FAIL add_strobes: pop=%0d tos=%0d push=%0d want 2/2/1", pop_cnt - q0, tos_cnt - t0, push_cnt - p0); end
    checks++; if (last_push !== 8'h10 || result !== 8'h10 || depth !== 4'd1) begin
      errors++; $display("FAIL add_result: data=%h result=%h depth=%0d want 10/10/1", last_push, result, depth); end
  endtask

  task automatic test_sub_dup();
    do_reset();
    run(PUSH, 8'h03, lat); run(PUSH, 8'h07, lat); run(SUB, 8'h00, lat);
    checks++; if (last_push !== 8'hFC || depth !== 4'd1) begin
      errors++; $display("FAIL sub_result: data=%h depth=%0d want FC/1", last_push, depth); end
    snap();
    run(DUP, 8'h00, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL dup_latency: got %0d want 3", lat); end
    checks++; if (pop_cnt - q0 !== 0 || tos_cnt - t0 !== 1 || push_cnt - p0 !== 1) begin
      errors++; $display("FAIL dup_strobes: pop=%0d tos=%0d push=%0d want 0/1/1", pop_cnt - q0, tos_cnt - t0, push_cnt - p0); end
    checks++; if (last_push !== 8'hFC || depth !== 4'd2) begin
      errors++; $display("FAIL dup_result: data=%h depth=%0d want FC/2", last_push, depth); end
  endtask

  task automatic test_logic();
    do_reset();
    run(PUSH, 8'h3C, lat); run(PUSH, 8'h0F, lat); run(AND, 8'h00, lat);
    checks++; if (last_push !== 8'h0C) begin errors++; $display("FAIL and_result: got %h want 0C", last_push); end
    run(PUSH, 8'h55, lat); run(XOR, 8'h00, lat);
    checks++; if (last_push !== 8'h59 || depth !== 4'd1) begin
      errors++; $display("FAIL xor_result: data=%h depth=%0d want 59/1", last_push, depth); end
    snap();
    run(NOP, 8'hEE, lat);
    checks++; if (lat !== 1 || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL nop_done: lat=%0d dones=%0d want 1/1", lat, done_cnt - d0); end
    checks++; if (push_cnt != p0 || pop_cnt != q0 || tos_cnt != t0 || depth !== 4'd1 || result !== 8'h59) begin
      errors++; $display("FAIL nop_effect: strobes or state changed, depth=%0d result=%h want 1/59", depth, result); end
  endtask

  task automatic test_boundary();
    do_reset(); snap();
    run(POP, 8'h00, lat);
`ifdef STACK_SEQ_GUARD_EN
    checks++; if (err_cnt - e0 !== 1 || pop_cnt != q0 || done_cnt - d0 !== 1 || depth !== 4'd0) begin
      errors++; $display("FAIL pop_empty: err=%0d pops=%0d depth=%0d want 1/0/0", err_cnt - e0, pop_cnt - q0, depth); end
`else
    checks++; if (err_cnt != e0 || pop_cnt - q0 !== 1 || done_cnt - d0 !== 1 || depth !== 4'd0) begin
      errors++; $display("FAIL pop_empty: err=%0d pops=%0d depth=%0d want 0/1/0", err_cnt - e0, pop_cnt - q0, depth); end
`endif
    for (int i = 0; i < 8; i++) run(PUSH, 8'(i + 1), lat);
    checks++; if (depth !== 4'd8) begin errors++; $display("FAIL fill_depth: got %0d want 8", depth); end
    snap();
    run(PUSH, 8'h99, lat);
`ifdef STACK_SEQ_GUARD_EN
    checks++; if (err_cnt - e0 !== 1 || push_cnt != p0 || depth !== 4'd8 || result !== 8'h08) begin
      errors++; $display("FAIL push_full: err=%0d pushes=%0d depth=%0d result=%h want 1/0/8/08", err_cnt - e0, push_cnt - p0, depth, result); end
`else
    checks++; if (err_cnt != e0 || push_cnt - p0 !== 1 || depth !== 4'd8 || result !== 8'h99) begin
      errors++; $display("FAIL push_full: err=%0d pushes=%0d depth=%0d result=%h want 0/1/8/99", err_cnt - e0, push_cnt - p0, depth, result); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    run(PUSH, 8'h11, lat); run(PUSH, 8'h22, lat);
    snap();
    issue(XOR, 8'h00);
    repeat (4) @(negedge clk);
    checks++; if (pop_sig !== 1'b1) begin errors++; $display("FAIL latb_pop: got %b want 1", pop_sig); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({push_sig, pop_sig, tos_sig, done} !== 4'b0 || depth !== 4'd0) begin
      errors++; $display("FAIL mid_reset: strobes=%b depth=%0d want 0000/0", {push_sig, pop_sig, tos_sig, done}, depth); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", instr_ready); end
    repeat (4) @(negedge clk);
    checks++; if (done_cnt != d0 || push_cnt != p0) begin
      errors++; $display("FAIL abandoned: dones=%0d pushes=%0d want 0/0", done_cnt - d0, push_cnt - p0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run(PUSH, 8'h01, lat); run(PUSH, 8'h02, lat);
    snap();
    instr_valid = 1'b1; opcode = ADD; imm = 8'h00;
    for (int t = 0; t < 20 && !instr_ready; t++) @(negedge clk);
    @(posedge clk);
    #1 opcode = PUSH; imm = 8'h77;
    wait_done(lat);
    instr_valid = 1'b0;
    @(negedge clk);
    checks++; if (lat !== 5 || done_cnt - d0 !== 1) begin
      errors++; $display("FAIL held_valid: lat=%0d dones=%0d want 5/1", lat, done_cnt - d0); end
    checks++; if (pop_cnt - q0 !== 2 || push_cnt - p0 !== 1 || result !== 8'h03 || depth !== 4'd1) begin
      errors++; $display("FAIL held_result: pops=%0d pushes=%0d result=%h depth=%0d want 2/1/03/1", pop_cnt - q0, push_cnt - p0, result, depth); end
  endtask

  initial begin
    test_reset();
    test_push();
    test_add();
    test_sub_dup();
    test_logic();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
